// File: rtl/ntt_mult_arb_pkg.sv
// Shared constants and request payload for the NTT multiplier arbiter.
package ntt_mult_arb_pkg;

  // Cycles from the accept edge to the visible response.
  localparam int unsigned NTT_MULT_ARB_LATENCY = 2;

  // Widest operand the request payload can carry; narrower RADIX values are zero-extended.
  localparam int unsigned NTT_MAX_RADIX = 32;

  typedef struct packed {
    logic [NTT_MAX_RADIX-1:0] a;
    logic [NTT_MAX_RADIX-1:0] b;
  } ntt_mult_req_t;

  // Requester index width, never narrower than one bit.
  function automatic int unsigned ntt_id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ntt_mult_dsp.sv
// Unsigned full-width multiplier between the two pipeline stages.
module ntt_mult_dsp
  import ntt_mult_arb_pkg::*;
#(
  parameter int unsigned RADIX = 23
) (
  input  logic [NTT_MAX_RADIX-1:0] i_a,
  input  logic [NTT_MAX_RADIX-1:0] i_b,
  output logic [2*RADIX-1:0]       o_p
);

  localparam int unsigned FULL_W = 2 * NTT_MAX_RADIX;

  // Operands are zero above RADIX, so the upper product bits are always zero.
  assign o_p = (2*RADIX)'(FULL_W'(i_a) * FULL_W'(i_b));

endmodule

// File: rtl/ntt_mult_arb.sv
// Round-robin arbiter feeding one shared two-stage multiplier pipeline.
module ntt_mult_arb
  import ntt_mult_arb_pkg::*;
#(
  parameter  int unsigned RADIX   = 23,
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = ntt_id_width(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       zeroize,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*RADIX-1:0]   req_a_i,
  input  logic [NUM_REQ*RADIX-1:0]   req_b_i,
  output logic                       rsp_valid_o,
  output logic [ID_W-1:0]            rsp_id_o,
  output logic [2*RADIX-1:0]         rsp_p_o,
  output logic                       busy_o
);

  if (RADIX == 0 || RADIX > NTT_MAX_RADIX || NUM_REQ == 0 || NUM_REQ > 8 ||
      NTT_MULT_ARB_LATENCY != 2) begin : g_cfg_err
    $error("ntt_mult_arb: unsupported RADIX/NUM_REQ configuration");
  end

  logic [ID_W-1:0]    r_rr_ptr;
  logic               w_hi_any;
  logic               w_lo_any;
  logic               w_gnt_any;
  logic               w_accept;
  logic [ID_W-1:0]    w_hi_id;
  logic [ID_W-1:0]    w_lo_id;
  logic [ID_W-1:0]    w_gnt_id;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [RADIX-1:0]   w_a_sel;
  logic [RADIX-1:0]   w_b_sel;

  ntt_mult_req_t      r_s1_req;
  logic [ID_W-1:0]    r_s1_id;
  logic               r_s1_vld;

  logic [2*RADIX-1:0] w_prod;
  logic [2*RADIX-1:0] r_s2_p;
  logic [ID_W-1:0]    r_s2_id;
  logic               r_s2_vld;

  // Round-robin search: lowest valid at or above rr_ptr, else lowest valid overall (wrap).
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_id  = '0;
    w_lo_any = 1'b0;
    w_lo_id  = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (req_valid_i[k]) begin
        if (!w_lo_any) begin
          w_lo_any = 1'b1;
          w_lo_id  = ID_W'(k);
        end
        if (!w_hi_any && (ID_W'(k) >= r_rr_ptr)) begin
          w_hi_any = 1'b1;
          w_hi_id  = ID_W'(k);
        end
      end
    end
    w_gnt_any = w_lo_any;
    w_gnt_id  = w_hi_any ? w_hi_id : w_lo_id;
  end

  // One-hot ready for the granted requester, gated off during reset and zeroize; operand mux.
  always_comb begin
    req_ready_o = '0;
    w_a_sel     = '0;
    w_b_sel     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (w_gnt_id == ID_W'(k)) begin
        req_ready_o[k] = w_gnt_any & ~reset & ~zeroize;
        w_a_sel        = req_a_i[k*RADIX +: RADIX];
        w_b_sel        = req_b_i[k*RADIX +: RADIX];
      end
    end
  end

  assign w_accept  = |req_ready_o;
  assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);

  // Stage 1: capture the accepted request and advance the round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_s1_vld <= 1'b0;
      r_s1_req <= '0;
      r_s1_id  <= '0;
    end else if (zeroize) begin
      r_rr_ptr <= '0;
      r_s1_vld <= 1'b0;
      r_s1_req <= '0;
      r_s1_id  <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_rr_ptr   <= w_ptr_nxt;
        r_s1_req.a <= NTT_MAX_RADIX'(w_a_sel);
        r_s1_req.b <= NTT_MAX_RADIX'(w_b_sel);
        r_s1_id    <= w_gnt_id;
      end
    end
  end

  ntt_mult_dsp #(
    .RADIX (RADIX)
  ) u_dsp (
    .i_a (r_s1_req.a),
    .i_b (r_s1_req.b),
    .o_p (w_prod)
  );

  // Stage 2: register the product; data holds its last value when no entry advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_vld <= 1'b0;
      r_s2_p   <= '0;
      r_s2_id  <= '0;
    end else if (zeroize) begin
      r_s2_vld <= 1'b0;
      r_s2_p   <= '0;
      r_s2_id  <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_p  <= w_prod;
        r_s2_id <= r_s1_id;
      end
    end
  end

  assign rsp_valid_o = r_s2_vld;
  assign rsp_id_o    = r_s2_id;
  assign rsp_p_o     = r_s2_p;
  assign busy_o      = r_s1_vld | r_s2_vld;

endmodule

// File: tb/tb_ntt_mult_arb.sv
// Self-checking bench for ntt_mult_arb against a queue-based reference model.
module tb_ntt_mult_arb;
  import ntt_mult_arb_pkg::*;

  localparam int N = 4;
  localparam int R = 23;

  logic            clk;
  logic            reset;
  logic            zeroize;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*R-1:0]  req_a_i;
  logic [N*R-1:0]  req_b_i;
  logic            rsp_valid_o;
  logic [1:0]      rsp_id_o;
  logic [2*R-1:0]  rsp_p_o;
  logic            busy_o;

  ntt_mult_arb #(.RADIX(R), .NUM_REQ(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .zeroize     (zeroize),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_p_o     (rsp_p_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected responses with the cycle they must appear in.
  typedef struct {
    int             due;
    int             id;
    logic [2*R-1:0] p;
  } exp_t;

  exp_t           q[$];
  int             m_ptr;
  int             cyc;
  int             mode;      // 0: no re-raise, 1: always re-raise, 2: random re-raise
  logic [2*R-1:0] last_p;
  int             last_id;
  bit             pend[N];
  logic [R-1:0]   op_a[N];
  logic [R-1:0]   op_b[N];
  int             vectors;
  int             miscompares;

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid_i[k]       = pend[k];
      req_a_i[k*R +: R]    = op_a[k];
      req_b_i[k*R +: R]    = op_b[k];
    end
  endtask

  task automatic new_ops(input int k);
    op_a[k] = R'($urandom);
    op_b[k] = R'($urandom);
  endtask

  // First valid requester at or after the pointer, circularly.
  function automatic logic [N-1:0] exp_ready();
    if (reset || zeroize) return '0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (m_ptr + i) % N;
      if (req_valid_i[idx]) return N'(1 << idx);
    end
    return '0;
  endfunction

  function automatic bit rsp_due();
    return (q.size() > 0) && (q[0].due == cyc);
  endfunction

  // Update the model for the current cycle, clock once, then drive the next cycle.
  task automatic advance();
    logic [N-1:0] g;
    g = exp_ready();
    if (rsp_due()) begin
      last_p  = q[0].p;
      last_id = q[0].id;
      void'(q.pop_front());
    end
    for (int k = 0; k < N; k++) begin
      if (g[k]) begin
        q.push_back('{due: cyc + int'(NTT_MULT_ARB_LATENCY), id: k,
                      p: (2*R)'(op_a[k]) * (2*R)'(op_b[k])});
        m_ptr   = (k + 1) % N;
        pend[k] = 1'b0;
        new_ops(k);
      end
    end
    if (zeroize) begin
      q.delete();
      m_ptr   = 0;
      last_p  = '0;
      last_id = 0;
    end
    for (int k = 0; k < N; k++) begin
      if (!pend[k]) begin
        if (mode == 1) begin
          pend[k] = 1'b1;
          new_ops(k);
        end else if (mode == 2 && $urandom_range(0, 9) < 6) begin
          pend[k] = 1'b1;
          new_ops(k);
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    drive();
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    zeroize = 1'b0;
    mode    = 0;
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b0;
      new_ops(k);
    end
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    q.delete();
    m_ptr   = 0;
    cyc     = 0;
    last_p  = '0;
    last_id = 0;
    drive();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    zeroize = 1'b0;
    for (int k = 0; k < N; k++) begin
      pend[k] = 1'b1;
      new_ops(k);
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL reset_ready: got %b want 0000", req_ready_o); end
    vectors++; if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
    vectors++; if (rsp_id_o !== 2'd0) begin miscompares++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id_o); end
    vectors++; if (rsp_p_o !== '0) begin miscompares++; $display("FAIL reset_rsp_p: got %h want 0", rsp_p_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_single();
    apply_reset();
    pend[0] = 1'b1; op_a[0] = 23'd3; op_b[0] = 23'd5;
    drive(); #1;
    vectors++; if (req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL single_ready: got %b want 0001", req_ready_o); end
    advance(); #1;
    vectors++; if (req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL single_ready_drop: got %b want 0000", req_ready_o); end
    vectors++; if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid_o); end
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL single_busy_s1: got %b want 1", busy_o); end
    advance(); #1;
    vectors++; if (rsp_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid_o); end
    vectors++; if (rsp_id_o !== 2'd0) begin miscompares++; $display("FAIL single_rsp_id: got %0d want 0", rsp_id_o); end
    vectors++; if (rsp_p_o !== 46'd15) begin miscompares++; $display("FAIL single_rsp_p: got %0d want 15", rsp_p_o); end
    advance(); #1;
    vectors++; if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_pulse: got %b want 0", rsp_valid_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL single_idle_busy: got %b want 0", busy_o); end
    vectors++; if (rsp_p_o !== 46'd15) begin miscompares++; $display("FAIL single_hold_p: got %0d want 15", rsp_p_o); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    mode = 1;
    for (int k = 0; k < N; k++) pend[k] = 1'b1;
    drive();
    for (int c = 0; c < 10; c++) begin
      #1;
      vectors++; if (req_ready_o !== 4'(1 << (c % 4))) begin miscompares++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready_o, 4'(1 << (c % 4))); end
      if (c >= 2) begin
        vectors++; if (rsp_valid_o !== 1'b1) begin miscompares++; $display("FAIL rr_rsp_valid c%0d: got %b want 1", c, rsp_valid_o); end
        vectors++; if (rsp_id_o !== 2'((c - 2) % 4)) begin miscompares++; $display("FAIL rr_rsp_id c%0d: got %0d want %0d", c, rsp_id_o, (c - 2) % 4); end
        vectors++;
        if (!rsp_due()) begin miscompares++; $display("FAIL rr_model_empty c%0d: got none want entry", c); end
        else if (rsp_p_o !== q[0].p) begin miscompares++; $display("FAIL rr_rsp_p c%0d: got %h want %h", c, rsp_p_o, q[0].p); end
      end
      advance();
    end
  endtask

  task automatic test_max_operands();
    apply_reset();
    pend[1] = 1'b1; op_a[1] = 23'h7FFFFF; op_b[1] = 23'h7FFFFF;
    drive(); #1;
    vectors++; if (req_ready_o !== 4'b0010) begin miscompares++; $display("FAIL max_ready: got %b want 0010", req_ready_o); end
    advance(); advance(); #1;
    vectors++; if (rsp_valid_o !== 1'b1) begin miscompares++; $display("FAIL max_rsp_valid: got %b want 1", rsp_valid_o); end
    vectors++; if (rsp_id_o !== 2'd1) begin miscompares++; $display("FAIL max_rsp_id: got %0d want 1", rsp_id_o); end
    vectors++; if (rsp_p_o !== 46'h3FFFFF000001) begin miscompares++; $display("FAIL max_rsp_p: got %h want 3fffff000001", rsp_p_o); end
  endtask

  task automatic test_ptr_wrap();
    logic [2*R-1:0] p_first;
    apply_reset();
    pend[2] = 1'b1;
    drive(); #1;
    p_first = (2*R)'(op_a[2]) * (2*R)'(op_b[2]);
    vectors++; if (req_ready_o !== 4'b0100) begin miscompares++; $display("FAIL wrap_first: got %b want 0100", req_ready_o); end
    advance();
    pend[2] = 1'b1;
    drive(); #1;
    vectors++; if (req_ready_o !== 4'b0100) begin miscompares++; $display("FAIL wrap_only2: got %b want 0100", req_ready_o); end
    advance(); #1;
    vectors++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd2) begin miscompares++; $display("FAIL wrap_rsp1: got v%b id%0d want v1 id2", rsp_valid_o, rsp_id_o); end
    vectors++; if (rsp_p_o !== p_first) begin miscompares++; $display("FAIL wrap_rsp1_p: got %h want %h", rsp_p_o, p_first); end
    pend[0] = 1'b1; pend[3] = 1'b1;
    drive(); #1;
    vectors++; if (req_ready_o !== 4'b1000) begin miscompares++; $display("FAIL wrap_ptr3: got %b want 1000", req_ready_o); end
    advance(); #1;
    vectors++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd2) begin miscompares++; $display("FAIL wrap_rsp2: got v%b id%0d want v1 id2", rsp_valid_o, rsp_id_o); end
    vectors++; if (req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL wrap_to0: got %b want 0001", req_ready_o); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    pend[0] = 1'b1; pend[1] = 1'b1;
    drive(); #1;
    vectors++; if (req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL rmid_g0: got %b want 0001", req_ready_o); end
    advance(); #1;
    vectors++; if (req_ready_o !== 4'b0010) begin miscompares++; $display("FAIL rmid_g1: got %b want 0010", req_ready_o); end
    advance(); #1;
    vectors++; if (busy_o !== 1'b1 || rsp_valid_o !== 1'b1) begin miscompares++; $display("FAIL rmid_inflight: got busy%b v%b want busy1 v1", busy_o, rsp_valid_o); end
    pend[2] = 1'b1;
    drive();
    reset = 1'b1;
    #1;
    vectors++; if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL rmid_rsp_valid: got %b want 0", rsp_valid_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", busy_o); end
    vectors++; if (req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL rmid_ready: got %b want 0000", req_ready_o); end
    @(negedge clk);
    reset = 1'b0;
    pend[2] = 1'b0;
    q.delete();
    m_ptr = 0;
    drive();
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin miscompares++; $display("FAIL rmid_stale c%0d: got v%b busy%b want 0 0", c, rsp_valid_o, busy_o); end
      advance();
    end
    pend[1] = 1'b1; pend[3] = 1'b1;
    drive(); #1;
    vectors++; if (req_ready_o !== 4'b0010) begin miscompares++; $display("FAIL rmid_from0: got %b want 0010", req_ready_o); end
  endtask

  task automatic test_zeroize();
    apply_reset();
    mode = 1;
    for (int k = 0; k < N; k++) pend[k] = 1'b1;
    drive();
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (req_ready_o !== 4'(1 << c)) begin miscompares++; $display("FAIL zero_pre c%0d: got %b want %b", c, req_ready_o, 4'(1 << c)); end
      advance();
    end
    zeroize = 1'b1;
    #1;
    vectors++; if (req_ready_o !== 4'b0000) begin miscompares++; $display("FAIL zero_ready: got %b want 0000", req_ready_o); end
    vectors++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd1) begin miscompares++; $display("FAIL zero_cycle_rsp: got v%b id%0d want v1 id1", rsp_valid_o, rsp_id_o); end
    advance();
    zeroize = 1'b0;
    #1;
    vectors++; if (req_ready_o !== 4'b0001) begin miscompares++; $display("FAIL zero_resume: got %b want 0001", req_ready_o); end
    vectors++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin miscompares++; $display("FAIL zero_dropped: got v%b busy%b want 0 0", rsp_valid_o, busy_o); end
    vectors++; if (rsp_p_o !== '0 || rsp_id_o !== 2'd0) begin miscompares++; $display("FAIL zero_cleared: got p%h id%0d want 0 0", rsp_p_o, rsp_id_o); end
    advance(); #1;
    vectors++; if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL zero_gap: got %b want 0", rsp_valid_o); end
    vectors++; if (req_ready_o !== 4'b0010) begin miscompares++; $display("FAIL zero_next: got %b want 0010", req_ready_o); end
    advance(); #1;
    vectors++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd0) begin miscompares++; $display("FAIL zero_first_rsp: got v%b id%0d want v1 id0", rsp_valid_o, rsp_id_o); end
  endtask

  task automatic test_random();
    apply_reset();
    mode = 2;
    for (int k = 0; k < N; k++) pend[k] = ($urandom_range(0, 1) == 1);
    drive();
    for (int c = 0; c < 400; c++) begin
      zeroize = ($urandom_range(0, 31) == 0);
      #1;
      vectors++; if (req_ready_o !== exp_ready()) begin miscompares++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready_o, exp_ready()); end
      vectors++; if (busy_o !== (q.size() != 0)) begin miscompares++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy_o, q.size() != 0); end
      if (rsp_due()) begin
        vectors++; if (rsp_valid_o !== 1'b1) begin miscompares++; $display("FAIL rnd_rsp_valid c%0d: got %b want 1", c, rsp_valid_o); end
        vectors++; if (rsp_id_o !== 2'(q[0].id) || rsp_p_o !== q[0].p) begin miscompares++; $display("FAIL rnd_rsp_data c%0d: got id%0d p%h want id%0d p%h", c, rsp_id_o, rsp_p_o, q[0].id, q[0].p); end
      end else begin
        vectors++; if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL rnd_spurious c%0d: got %b want 0", c, rsp_valid_o); end
        vectors++; if (rsp_id_o !== 2'(last_id) || rsp_p_o !== last_p) begin miscompares++; $display("FAIL rnd_hold c%0d: got id%0d p%h want id%0d p%h", c, rsp_id_o, rsp_p_o, last_id, last_p); end
      end
      advance();
    end
    zeroize = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    zeroize     = 1'b0;
    req_valid_i = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    m_ptr       = 0;
    cyc         = 0;
    mode        = 0;
    last_p      = '0;
    last_id     = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_max_operands();
    test_ptr_wrap();
    test_reset_midflight();
    test_zeroize();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ntt_mult_arb.md
NTT_MULT_ARB -- requirements
Module: ntt_mult_arb

Interface
REQ-001 SHALL have parameter RADIX, default 23: operand width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the multiplier; legal range 1..8.
REQ-003 SHALL derive ID_W = max(1, clog2(NUM_REQ)) as a local constant.
REQ-004 SHALL have ports:
  - clk  input  1  clock; single clock domain, all state on its rising edge.
  - reset  input  1  asynchronous, active-high reset.
  - zeroize  input  1  synchronous clear of all state.
  - req_valid_i  input  NUM_REQ  per-requester request valid.
  - req_ready_o  output  NUM_REQ  per-requester accept strobe.
  - req_a_i  input  NUM_REQ x RADIX  per-requester operand A.
  - req_b_i  input  NUM_REQ x RADIX  per-requester operand B.
  - rsp_valid_o  output  1  result valid, single-cycle pulse per request.
  - rsp_id_o  output  ID_W  index of the requester that owns the result.
  - rsp_p_o  output  2*RADIX  product A*B.
  - busy_o  output  1  high while any pipeline stage holds a valid entry.

Function
REQ-005 SHALL arbitrate round-robin: grant the first requester with valid high, searching from rr_ptr upward with wrap from NUM_REQ-1 to 0.
REQ-006 SHALL drive req_ready_o combinationally, one-hot or zero: at most the granted bit, never for a requester with valid low.
REQ-007 SHALL treat a request as accepted in a cycle where req_valid_i[k] and req_ready_o[k] are both high.
REQ-008 SHALL, on accept of requester k, set rr_ptr to (k+1) mod NUM_REQ; rr_ptr SHALL hold when no accept occurs.
REQ-009 SHALL register operands, id and valid in stage 1 on accept; stage-1 valid SHALL clear when no accept occurs.
REQ-010 SHALL multiply the stage-1 operands combinationally, unsigned, full 2*RADIX-bit result, with no truncation or reduction.
REQ-011 SHALL register product, id and valid in stage 2; the stage-2 registers SHALL drive rsp_p_o, rsp_id_o and rsp_valid_o directly.
REQ-012 SHALL produce rsp_valid_o exactly 2 cycles after the accept edge, with fixed latency and no response backpressure.
REQ-013 SHALL sustain one accept per cycle; results SHALL leave in accept order.
REQ-014 SHALL hold rsp_p_o and rsp_id_o at their last values when rsp_valid_o is low; consumers SHALL qualify them with rsp_valid_o.
REQ-015 SHALL drive busy_o as the OR of the stage-1 and stage-2 valid bits.
REQ-016 SHALL, with NUM_REQ=1, reduce the grant to req_ready_o = req_valid_i and fix rsp_id_o at 0.
REQ-017 SHALL, while zeroize is high, force req_ready_o to 0 and, on that edge, clear rr_ptr, both valid bits and all data registers; in-flight requests SHALL be dropped and SHALL produce no response.
REQ-018 SHALL not require requesters to hold operands stable beyond the accept cycle; a requester SHALL keep valid high until ready.

Reset
REQ-019 SHALL asynchronously set, on reset high: rr_ptr=0, stage valids=0, all data registers=0, giving rsp_valid_o=0, rsp_id_o=0, rsp_p_o=0 and busy_o=0.
REQ-020 SHALL, on reset mid-operation, discard in-flight entries immediately; no response for them SHALL appear after reset deasserts.
REQ-021 SHALL keep req_ready_o at 0 while reset is high.

Structure
REQ-022 SHALL take NTT_MULT_ARB_LATENCY (=2) and the request struct typedef (a, b) from the shared package ntt_mult_arb_pkg.
REQ-023 SHALL contain exactly one ntt_mult_dsp instance (RADIX passed through) between stage 1 and stage 2; no other sub-modules.

Verification
REQ-024 Single request: req0 a=3, b=5 at cycle 0 -> ready0=1 at cycle 0; rsp_valid_o=1, rsp_id_o=0, rsp_p_o=15 at cycle 2.
REQ-025 All four valid continuously from reset -> grants 0,1,2,3,0,1 on consecutive cycles; one response per cycle, ids in the same order.
REQ-026 Max operands: a=b=0x7FFFFF -> rsp_p_o=0x3FFFFF000001.
REQ-027 With rr_ptr=3, only req2 valid -> req2 granted; rr_ptr becomes 3; result id 2.
REQ-028 Reset asserted with two requests in flight -> rsp_valid_o and busy_o low immediately; no stale response after release; next grant searches from requester 0.
REQ-029 Zeroize for 1 cycle mid-stream -> req_ready_o=0 during that cycle; dropped requests yield no response; the stream resumes next cycle with rr_ptr=0.
